// File: rtl/tawas_rcn_pkg.sv
// Shared widths, byte-mask encodings, error-bit indices and the load
// extraction helper for the tawas rcn response path.
package tawas_rcn_pkg;

   localparam int SEQ_W  = 5;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   // Completion byte-mask encodings (lanes in natural position)
   localparam logic [MASK_W-1:0] MASK_B0   = 4'b0001;
   localparam logic [MASK_W-1:0] MASK_B1   = 4'b0010;
   localparam logic [MASK_W-1:0] MASK_B2   = 4'b0100;
   localparam logic [MASK_W-1:0] MASK_B3   = 4'b1000;
   localparam logic [MASK_W-1:0] MASK_H0   = 4'b0011;
   localparam logic [MASK_W-1:0] MASK_H1   = 4'b1100;
   localparam logic [MASK_W-1:0] MASK_WORD = 4'b1111;

   // Sticky error bit positions
   localparam int ERR_CPL = 0;   // completion for a non-pending tag
   localparam int ERR_ISS = 1;   // issue to an already pending tag
   localparam int ERR_OVF = 2;   // read-result FIFO overflow

   // Pull the addressed byte/half out of its lane and zero/sign extend it.
   // Unrecognised masks are passed through as a full word.
   function automatic logic [DATA_W-1:0] rsp_extract(
      input logic [MASK_W-1:0] mask,
      input logic [DATA_W-1:0] data,
      input logic              sext
   );
      logic [DATA_W-1:0] res;
      case (mask)
         MASK_B0:   res = {{24{sext & data[7]}},  data[7:0]};
         MASK_B1:   res = {{24{sext & data[15]}}, data[15:8]};
         MASK_B2:   res = {{24{sext & data[23]}}, data[23:16]};
         MASK_B3:   res = {{24{sext & data[31]}}, data[31:24]};
         MASK_H0:   res = {{16{sext & data[15]}}, data[15:0]};
         MASK_H1:   res = {{16{sext & data[31]}}, data[31:16]};
         MASK_WORD: res = data;
         default:   res = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/tawas_rcn_rsp_unit_if.sv
// Bundle of the issue, completion and register-file write signals around
// the rcn response unit. The unit takes the slave side.
interface tawas_rcn_rsp_unit_if;
   import tawas_rcn_pkg::*;

   logic                issue;
   logic [SEQ_W-1:0]    issue_seq;
   logic                issue_wr;
   logic                issue_sext;
   logic                rdone;
   logic                wdone;
   logic [SEQ_W-1:0]    rsp_seq;
   logic [MASK_W-1:0]   rsp_mask;
   logic [23:0]         rsp_addr;
   logic [DATA_W-1:0]   rsp_data;
   logic [31:0]         pend;
   logic                rf_vld;
   logic                rf_rdy;
   logic [SEQ_W-1:0]    rf_seq;
   logic [DATA_W-1:0]   rf_data;
   logic [2:0]          err;

   modport slave (
      input  issue, issue_seq, issue_wr, issue_sext,
      input  rdone, wdone, rsp_seq, rsp_mask, rsp_addr, rsp_data,
      input  rf_rdy,
      output pend, rf_vld, rf_seq, rf_data, err
   );

   modport master (
      output issue, issue_seq, issue_wr, issue_sext,
      output rdone, wdone, rsp_seq, rsp_mask, rsp_addr, rsp_data,
      output rf_rdy,
      input  pend, rf_vld, rf_seq, rf_data, err
   );

endinterface

// File: rtl/tawas_rcn_rsp_fifo.sv
// Synchronous FIFO whose head is held in an output register, so a push into
// an empty FIFO is visible on out_vld after one edge. Capacity is DEPTH
// entries in total; push and pop together are accepted even when full.
module tawas_rcn_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rdy,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_data,
   output logic             full,
   output logic             empty,
   output logic             ovf
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] cnt_r;
   logic             out_vld_r;
   logic [WIDTH-1:0] out_data_r;

   logic             pop_s;
   logic             full_s;
   logic             wr_en_s;
   logic [PTR_W-1:0] rd_ptr_n_s;
   logic [CNT_W-1:0] remain_s;
   logic [CNT_W-1:0] cnt_n_s;
   logic [WIDTH-1:0] head_n_s;

   // Next-state of pointers, count and the head that the output register loads
   always_comb begin
      pop_s      = out_vld_r & rdy;
      full_s     = (cnt_r == CNT_W'(DEPTH));
      wr_en_s    = push & (~full_s | pop_s);
      rd_ptr_n_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
      remain_s   = cnt_r - CNT_W'(pop_s);
      cnt_n_s    = remain_s + CNT_W'(wr_en_s);
      if (remain_s != {CNT_W{1'b0}}) begin
         head_n_s = mem_r[rd_ptr_n_s];
      end else if (wr_en_s) begin
         head_n_s = wdata;
      end else begin
         head_n_s = out_data_r;
      end
   end

   // Storage array: written on every accepted push, no reset needed
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Control state and the registered head
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         out_vld_r  <= 1'b0;
         out_data_r <= {WIDTH{1'b0}};
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         rd_ptr_r   <= rd_ptr_n_s;
         cnt_r      <= cnt_n_s;
         out_vld_r  <= (cnt_n_s != {CNT_W{1'b0}});
         out_data_r <= head_n_s;
      end
   end

   assign out_vld  = out_vld_r;
   assign out_data = out_data_r;
   assign full     = full_s;
   assign empty    = (cnt_r == {CNT_W{1'b0}});
   assign ovf      = push & full_s & ~pop_s;

endmodule

// File: rtl/tawas_rcn_rsp_unit.sv
// Response unit downstream of the buffered rcn master: per-tag pending
// scoreboard, load extraction and a read-result FIFO toward the register
// file. Optional build macro TAWAS_RCN_RSP_CHECK_EN enables the protocol
// checks that drive err[1:0]; without it those bits stay 0.
module tawas_rcn_rsp_unit
   import tawas_rcn_pkg::*;
#(
   parameter int RSP_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   tawas_rcn_rsp_unit_if.slave  bus
);

   localparam int ENT_W = SEQ_W + DATA_W;

   logic [31:0]       pend_r;
   logic [31:0]       sext_r;
   logic [2:0]        err_r;

   logic              cpl_ok_s;
   logic              err_cpl_s;
   logic              err_iss_s;
   logic              wclr_s;
   logic              push_s;
   logic              pop_s;
   logic [31:0]       set_s;
   logic [31:0]       clr_s;
   logic [31:0]       pend_n_s;
   logic [DATA_W-1:0] ext_data_s;

   logic              fifo_vld_s;
   logic [ENT_W-1:0]  fifo_out_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              fifo_ovf_s;
   logic              unused_s;

`ifdef TAWAS_RCN_RSP_CHECK_EN
   assign cpl_ok_s  = pend_r[bus.rsp_seq];
   assign err_cpl_s = (bus.rdone | bus.wdone) & ~pend_r[bus.rsp_seq];
   assign err_iss_s = bus.issue & pend_r[bus.issue_seq];
`else
   assign cpl_ok_s  = 1'b1;
   assign err_cpl_s = 1'b0;
   assign err_iss_s = 1'b0;
`endif

   // Completion decode, extraction and next pending vector (set beats clear)
   always_comb begin
      push_s     = bus.rdone & cpl_ok_s;
      wclr_s     = bus.wdone & ~bus.rdone & cpl_ok_s;
      pop_s      = fifo_vld_s & bus.rf_rdy;
      ext_data_s = rsp_extract(bus.rsp_mask, bus.rsp_data, sext_r[bus.rsp_seq]);
      set_s      = {31'b0, bus.issue} << bus.issue_seq;
      clr_s      = ({31'b0, wclr_s} << bus.rsp_seq)
                 | ({31'b0, pop_s}  << fifo_out_s[ENT_W-1 -: SEQ_W]);
      pend_n_s   = (pend_r & ~clr_s) | set_s;
   end

   // Scoreboard, per-tag sign-extend flags and sticky error bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r <= 32'h0000_0000;
         sext_r <= 32'h0000_0000;
         err_r  <= 3'b000;
      end else begin
         pend_r <= pend_n_s;
         if (bus.issue) begin
            sext_r[bus.issue_seq] <= bus.issue_sext;
         end
         err_r[ERR_CPL] <= err_r[ERR_CPL] | err_cpl_s;
         err_r[ERR_ISS] <= err_r[ERR_ISS] | err_iss_s;
         err_r[ERR_OVF] <= err_r[ERR_OVF] | fifo_ovf_s;
      end
   end

   tawas_rcn_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_s),
      .wdata    ({bus.rsp_seq, ext_data_s}),
      .rdy      (bus.rf_rdy),
      .out_vld  (fifo_vld_s),
      .out_data (fifo_out_s),
      .full     (fifo_full_s),
      .empty    (fifo_empty_s),
      .ovf      (fifo_ovf_s)
   );

   assign bus.pend    = pend_r;
   assign bus.err     = err_r;
   assign bus.rf_vld  = fifo_vld_s;
   assign bus.rf_seq  = fifo_out_s[ENT_W-1 -: SEQ_W];
   assign bus.rf_data = fifo_out_s[DATA_W-1:0];

   // Debug-only address and write flag, plus FIFO status, are not consumed here
   assign unused_s = ^{bus.rsp_addr, bus.issue_wr, fifo_full_s, fifo_empty_s};

endmodule
